// File: rtl/sram_1rw_hs_wrap.sv
// sram_1rw_hs_wrap
//   Wraps one 1RW SRAM macro behind a valid/ready request port. The macro
//   clock is generated by dividing clk_i by CLK_DIV. Macro inputs only change
//   on slot edges: the clk_i edge that ends the divider's last count. The
//   macro therefore samples stable inputs on its rising edge, which falls
//   mid-period. Read data is captured RD_WAIT macro periods after launch
//   and then held.
//
//   Optional feature macro: SRAM_PERF_CNT_EN adds the saturating read and
//   write counters rd_cnt_o and wr_cnt_o.
//
// Ports
//   clk_i, rst_n_i        system clock, async active-low reset
//   req_*_i / req_ready_o request port; ready only while idle
//   rd_data_o             last captured read data, held between reads
//   rd_valid_o            one-cycle pulse when rd_data_o is updated
//   wr_done_o             one-cycle pulse when a write is committed
//   sram_*_o, sram_dout_i macro interface; din/dout carry an unused spare MSB
//   rd_cnt_o, wr_cnt_o    completed reads/writes (SRAM_PERF_CNT_EN only)
//
// State | meaning
//   IDLE   | ready for a request
//   LAUNCH | request latched, waiting for the next slot edge to drive the macro
//   ACCESS | csb low for one macro period
//   WAIT   | read in flight, waiting for the capture slot edge
module sram_1rw_hs_wrap #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 10,
    parameter int NUM_WMASKS = 8,
    parameter int CLK_DIV    = 4,
    parameter int RD_WAIT    = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    input  logic [NUM_WMASKS-1:0] req_wmask_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  rd_valid_o,
    output logic                  wr_done_o,
    output logic                  sram_clk_o,
    output logic                  sram_csb_o,
    output logic                  sram_web_o,
    output logic [NUM_WMASKS-1:0] sram_wmask_o,
    output logic                  sram_spare_wen_o,
    output logic [ADDR_WIDTH-1:0] sram_addr_o,
    output logic [DATA_WIDTH:0]   sram_din_o,
    input  logic [DATA_WIDTH:0]   sram_dout_i
`ifdef SRAM_PERF_CNT_EN
    ,
    output logic [31:0]           rd_cnt_o,
    output logic [31:0]           wr_cnt_o
`endif
);

    typedef enum logic [1:0] {IDLE, LAUNCH, ACCESS, WAIT} state_e;

    localparam int DCW = $clog2(CLK_DIV);
    localparam int WCW = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;
    localparam logic [DCW-1:0] DIV_LAST = DCW'(CLK_DIV - 1);
    localparam logic [DCW-1:0] DIV_HALF = DCW'(CLK_DIV / 2);

    state_e                state_q, state_d;
    logic [DCW-1:0]        div_cnt_q, div_cnt_d;
    logic                  sram_clk_q, sram_clk_d;
    logic [WCW-1:0]        wait_q, wait_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [NUM_WMASKS-1:0] wmask_q, wmask_d;
    logic                  csb_q, csb_d;
    logic                  web_q, web_d;
    logic [NUM_WMASKS-1:0] mwmask_q, mwmask_d;
    logic [ADDR_WIDTH-1:0] maddr_q, maddr_d;
    logic [DATA_WIDTH:0]   din_q, din_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  wr_done_q, wr_done_d;
    logic                  slot;
    logic                  unused_dout_spare;

    assign slot              = (div_cnt_q == DIV_LAST);
    assign unused_dout_spare = sram_dout_i[DATA_WIDTH];

    always_comb begin
        state_d    = state_q;
        div_cnt_d  = slot ? '0 : div_cnt_q + 1'b1;
        // Registered from the next count so sram_clk_q always equals
        // (div_cnt_q >= CLK_DIV/2) without a combinational output.
        sram_clk_d = (div_cnt_d >= DIV_HALF);
        wait_d     = wait_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wmask_d    = wmask_q;
        csb_d      = csb_q;
        web_d      = web_q;
        mwmask_d   = mwmask_q;
        maddr_d    = maddr_q;
        din_d      = din_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        wr_done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    we_d    = req_we_i;
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                    wmask_d = req_wmask_i;
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                if (slot) begin
                    csb_d    = 1'b0;
                    web_d    = ~we_q;
                    maddr_d  = addr_q;
                    din_d    = {1'b0, wdata_q};
                    mwmask_d = wmask_q;
                    state_d  = ACCESS;
                end
            end
            ACCESS: begin
                if (slot) begin
                    csb_d = 1'b1;
                    web_d = 1'b1;
                    if (we_q) begin
                        wr_done_d = 1'b1;
                        state_d   = IDLE;
                    end else if (RD_WAIT == 1) begin
                        rd_data_d  = sram_dout_i[DATA_WIDTH-1:0];
                        rd_valid_d = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        wait_d  = WCW'(RD_WAIT - 1);
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (slot) begin
                    if (wait_q == WCW'(1)) begin
                        rd_data_d  = sram_dout_i[DATA_WIDTH-1:0];
                        rd_valid_d = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        wait_d = wait_q - 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            div_cnt_q  <= '0;
            sram_clk_q <= 1'b0;
            wait_q     <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wmask_q    <= '0;
            csb_q      <= 1'b1;
            web_q      <= 1'b1;
            mwmask_q   <= '0;
            maddr_q    <= '0;
            din_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            wr_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            sram_clk_q <= sram_clk_d;
            wait_q     <= wait_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wmask_q    <= wmask_d;
            csb_q      <= csb_d;
            web_q      <= web_d;
            mwmask_q   <= mwmask_d;
            maddr_q    <= maddr_d;
            din_q      <= din_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            wr_done_q  <= wr_done_d;
        end
    end

    assign req_ready_o      = (state_q == IDLE);
    assign rd_data_o        = rd_data_q;
    assign rd_valid_o       = rd_valid_q;
    assign wr_done_o        = wr_done_q;
    assign sram_clk_o       = sram_clk_q;
    assign sram_csb_o       = csb_q;
    assign sram_web_o       = web_q;
    assign sram_wmask_o     = mwmask_q;
    assign sram_spare_wen_o = 1'b0;
    assign sram_addr_o      = maddr_q;
    assign sram_din_o       = din_q;

`ifdef SRAM_PERF_CNT_EN
    logic [31:0] rd_cnt_q, wr_cnt_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            if (rd_valid_q && (rd_cnt_q != 32'hFFFF_FFFF)) rd_cnt_q <= rd_cnt_q + 32'd1;
            if (wr_done_q && (wr_cnt_q != 32'hFFFF_FFFF)) wr_cnt_q <= wr_cnt_q + 32'd1;
        end
    end

    assign rd_cnt_o = rd_cnt_q;
    assign wr_cnt_o = wr_cnt_q;
`endif

endmodule

// File: tb/tb_sram_1rw_hs_wrap.sv
module tb_sram_1rw_hs_wrap;
    localparam int DW = 64;
    localparam int AW = 10;
    localparam int NM = 8;
    localparam int CD = 4;
    localparam int RW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [NM-1:0] req_wmask = '0;
    logic [DW-1:0] rd_data;
    logic          rd_valid, wr_done;
    logic          sram_clk, sram_csb, sram_web, sram_spare_wen;
    logic [NM-1:0] sram_wmask;
    logic [AW-1:0] sram_addr;
    logic [DW:0]   sram_din;
    logic [DW:0]   sram_dout = '0;
`ifdef SRAM_PERF_CNT_EN
    logic [31:0]   rd_cnt, wr_cnt;
`endif

    sram_1rw_hs_wrap #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WMASKS(NM),
                       .CLK_DIV(CD), .RD_WAIT(RW)) dut (
        .clk_i            (clk),
        .rst_n_i          (rst_n),
        .req_valid_i      (req_valid),
        .req_ready_o      (req_ready),
        .req_we_i         (req_we),
        .req_addr_i       (req_addr),
        .req_wdata_i      (req_wdata),
        .req_wmask_i      (req_wmask),
        .rd_data_o        (rd_data),
        .rd_valid_o       (rd_valid),
        .wr_done_o        (wr_done),
        .sram_clk_o       (sram_clk),
        .sram_csb_o       (sram_csb),
        .sram_web_o       (sram_web),
        .sram_wmask_o     (sram_wmask),
        .sram_spare_wen_o (sram_spare_wen),
        .sram_addr_o      (sram_addr),
        .sram_din_o       (sram_din),
        .sram_dout_i      (sram_dout)
`ifdef SRAM_PERF_CNT_EN
        ,
        .rd_cnt_o         (rd_cnt),
        .wr_cnt_o         (wr_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Macro stand-in: samples controls on its rising clock, spare dout bit is junk.
    logic [DW-1:0] macro_mem [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem   [0:(1<<AW)-1];
    logic [DW-1:0] mw;
    always @(posedge sram_clk) begin
        if (!sram_csb) begin
            if (!sram_web) begin
                mw = macro_mem[sram_addr];
                for (int b = 0; b < NM; b++)
                    if (sram_wmask[b]) mw[b*8 +: 8] = sram_din[b*8 +: 8];
                macro_mem[sram_addr] = mw;
            end else begin
                sram_dout <= {1'($urandom), macro_mem[sram_addr]};
            end
        end
    end

    // Reference model: edge k (counted from reset release) is a slot edge
    // when k is a multiple of CD. Everything else follows from arithmetic.
    int            cyc = 0;
    bit            model_on = 1'b0;
    bit            busy = 1'b0;
    int            launch_e = 0, done_e = 0;
    bit            p_rd = 1'b0;
    logic [AW-1:0] p_addr = '0;
    logic [DW-1:0] p_wdata = '0, p_data = '0;
    logic [NM-1:0] p_mask = '0;
    bit            exp_ready = 1'b1, exp_rv = 1'b0, exp_wd = 1'b0, exp_csb = 1'b1;
    logic [DW-1:0] exp_rdata = '0;
    int            n_rd = 0, n_wr = 0;
    bit            rdy_before;
    logic [DW-1:0] rw;

    always @(posedge clk) begin
        if (model_on) begin
            rdy_before = exp_ready;
            cyc++;
            exp_rv = 1'b0;
            exp_wd = 1'b0;
            if (busy && cyc == launch_e) exp_csb = 1'b0;
            if (busy && cyc == launch_e + CD) exp_csb = 1'b1;
            if (busy && cyc == done_e) begin
                busy = 1'b0;
                if (p_rd) begin exp_rv = 1'b1; exp_rdata = p_data; n_rd++; end
                else begin exp_wd = 1'b1; n_wr++; end
            end
            if (rdy_before && req_valid) begin
                busy     = 1'b1;
                p_rd     = !req_we;
                p_addr   = req_addr;
                p_wdata  = req_wdata;
                p_mask   = req_wmask;
                launch_e = (cyc / CD + 1) * CD;
                done_e   = p_rd ? launch_e + RW * CD : launch_e + CD;
                if (p_rd) p_data = ref_mem[req_addr];
                else begin
                    rw = ref_mem[req_addr];
                    for (int b = 0; b < NM; b++)
                        if (req_wmask[b]) rw[b*8 +: 8] = req_wdata[b*8 +: 8];
                    ref_mem[req_addr] = rw;
                end
            end
            exp_ready = !busy;
        end
    end

    always @(negedge clk) begin
        if (model_on && rst_n) begin
            check("req_ready", 128'(req_ready), 128'(exp_ready));
            check("rd_valid", 128'(rd_valid), 128'(exp_rv));
            check("wr_done", 128'(wr_done), 128'(exp_wd));
            check("rd_data", 128'(rd_data), 128'(exp_rdata));
            check("sram_csb", 128'(sram_csb), 128'(exp_csb));
            check("sram_web", 128'(sram_web), 128'(exp_csb ? 1'b1 : p_rd));
            check("sram_clk", 128'(sram_clk), 128'((cyc % CD) >= CD / 2));
            check("spare_wen", 128'(sram_spare_wen), 128'(0));
            if (!exp_csb) begin
                check("sram_addr", 128'(sram_addr), 128'(p_addr));
                check("din_spare", 128'(sram_din[DW]), 128'(0));
                if (!p_rd) begin
                    check("sram_din", 128'(sram_din[DW-1:0]), 128'(p_wdata));
                    check("sram_wmask", 128'(sram_wmask), 128'(p_mask));
                end
            end
        end
    end

    task automatic do_req(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [NM-1:0] m, input bit hold, output int acc);
        int n = 0;
        req_we = we; req_addr = a; req_wdata = d; req_wmask = m; req_valid = 1'b1;
        while (!req_ready && n < 200) begin @(negedge clk); n++; end
        check("req_accept_timeout", 128'(req_ready), 128'(1));
        acc = cyc + 1;
        @(negedge clk);
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic wait_done(input bit rd, input int acc, output int lat, output logic [DW-1:0] data);
        int n = 0;
        lat = -1;
        data = '0;
        while (n < 40) begin
            if (rd ? rd_valid : wr_done) begin
                lat = cyc - acc;
                data = rd_data;
                break;
            end
            @(negedge clk);
            n++;
        end
        check(rd ? "rd_valid_timeout" : "wr_done_timeout", 128'(lat >= 0), 128'(1));
        if (rd) check("rd_latency_range", 128'(lat >= RW*CD+1 && lat <= RW*CD+CD), 128'(1));
        else    check("wr_latency_range", 128'(lat >= CD+1 && lat <= 2*CD), 128'(1));
    endtask

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    int            acc, acc2, lat, n, csb_low;
    int            rise[$];
    bit            prev;
    logic [DW-1:0] d;
    logic [AW-1:0] ra;
    logic [NM-1:0] rm;
    bit            rwe;
    int            mode;

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            macro_mem[i] = {$urandom, $urandom};
            ref_mem[i]   = macro_mem[i];
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_on = 1'b1;

        // Idle after reset: sram_clk period
        prev = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (sram_clk && !prev) rise.push_back(cyc);
            prev = sram_clk;
        end
        check("sram_clk_rises", 128'(rise.size() >= 2), 128'(1));
        if (rise.size() >= 2) check("sram_clk_period", 128'(rise[1] - rise[0]), 128'(4));
        check("rd_data_reset", 128'(rd_data), 128'(0));

        // Full write then read
        do_req(1'b1, 10'h015, 64'h0123_4567_89AB_CDEF, 8'hFF, 1'b0, acc);
        wait_done(1'b0, acc, lat, d);
        do_req(1'b0, 10'h015, '0, '0, 1'b0, acc);
        wait_done(1'b1, acc, lat, d);
        check("read_full_word", 128'(d), 128'(64'h0123_4567_89AB_CDEF));
        repeat (20) @(negedge clk);
        check("rd_data_held", 128'(rd_data), 128'(64'h0123_4567_89AB_CDEF));

        // Partial write (low four bytes) then read
        do_req(1'b1, 10'h015, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 1'b0, acc);
        wait_done(1'b0, acc, lat, d);
        do_req(1'b0, 10'h015, '0, '0, 1'b0, acc);
        wait_done(1'b1, acc, lat, d);
        check("read_masked", 128'(d), 128'(64'h0123_4567_FFFF_FFFF));

        // Zero-mask write still completes and changes nothing
        do_req(1'b1, 10'h015, 64'h0, 8'h00, 1'b0, acc);
        wait_done(1'b0, acc, lat, d);
        check("rd_data_after_write", 128'(rd_data), 128'(64'h0123_4567_FFFF_FFFF));

        // Top address
        do_req(1'b1, 10'h3FF, 64'hA5A5_5A5A_0F0F_F0F0, 8'hFF, 1'b0, acc);
        wait_done(1'b0, acc, lat, d);
        do_req(1'b0, 10'h3FF, '0, '0, 1'b0, acc);
        wait_done(1'b1, acc, lat, d);
        check("read_top_addr", 128'(d), 128'(64'hA5A5_5A5A_0F0F_F0F0));

        // Request held high through a read
        do_req(1'b0, 10'h015, '0, '0, 1'b1, acc);
        csb_low = 0;
        n = 0;
        while (!rd_valid && n < 40) begin
            if (!sram_csb) csb_low++;
            @(negedge clk);
            n++;
        end
        check("held_rd_valid_seen", 128'(rd_valid), 128'(1));
        check("held_csb_low_cycles", 128'(csb_low), 128'(4));
        check("held_ready_in_rd_valid", 128'(req_ready), 128'(1));
        @(negedge clk);
        acc2 = cyc;
        req_valid = 1'b0;
        check("held_second_accepted", 128'(req_ready), 128'(0));
        wait_done(1'b1, acc2, lat, d);
        check("held_second_data", 128'(d), 128'(64'h0123_4567_FFFF_FFFF));

        // Reset during WAIT of a read
        do_req(1'b0, 10'h3FF, '0, '0, 1'b0, acc);
        n = 0;
        while (cyc < (acc / CD + 1) * CD + CD + 1 && n < 40) begin @(negedge clk); n++; end
        model_on = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_csb", 128'(sram_csb), 128'(1));
        check("rst_rd_data", 128'(rd_data), 128'(0));
        repeat (3) begin
            @(negedge clk);
            check("rst_no_rd_valid", 128'(rd_valid), 128'(0));
        end
        busy = 1'b0; exp_ready = 1'b1; exp_csb = 1'b1; exp_rv = 1'b0; exp_wd = 1'b0;
        exp_rdata = '0; cyc = 0; n_rd = 0; n_wr = 0;
        rst_n = 1'b1;
        model_on = 1'b1;
        repeat (12) @(negedge clk);
        do_req(1'b0, 10'h015, '0, '0, 1'b0, acc);
        wait_done(1'b1, acc, lat, d);
        check("read_after_reset", 128'(d), 128'(64'h0123_4567_FFFF_FFFF));

        // Randomised traffic; model checks every cycle
        for (int i = 0; i < 150; i++) begin
            rwe = 1'($urandom_range(0, 1));
            ra  = ($urandom_range(0, 9) == 0) ? 10'h3FF : AW'($urandom_range(0, 31));
            rm  = NM'($urandom);
            if ($urandom_range(0, 7) == 0) rm = '0;
            d   = {$urandom, $urandom};
            do_req(rwe, ra, d, rm, 1'b0, acc);
            mode = $urandom_range(0, 2);
            if (mode == 0) wait_done(!rwe, acc, lat, d);
            else if (mode == 1) repeat ($urandom_range(0, 15)) @(negedge clk);
        end
        repeat (40) @(negedge clk);

`ifdef SRAM_PERF_CNT_EN
        check("rd_cnt", 128'(rd_cnt), 128'(n_rd));
        check("wr_cnt", 128'(wr_cnt), 128'(n_wr));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
